// File: rtl/hwag_div_sched_pkg.sv
// Shared constants for the divider scheduler: FSM encoding, default sizes and an all-ones helper.
package hwag_div_sched_pkg;

    localparam int unsigned DefNch        = 4;
    localparam int unsigned DefWidth      = 24;
    localparam int unsigned DefTimeoutCyc = 64;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StStore = 2'd3;

    function automatic logic [63:0] all_ones(input int unsigned width);
        if (width >= 64) return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/hwag_rr_pick.sv
// Combinational round-robin picker: searches from last_i+1 upward, wrapping modulo NCH.
module hwag_rr_pick #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  last_i,
    output logic [IW-1:0]  gnt_o,
    output logic           valid_o
);

    int unsigned idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(last_i) + k) % NCH;
            if (!valid_o && req_i[idx[IW-1:0]]) begin
                valid_o = 1'b1;
                gnt_o   = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/hwag_div_sched.sv
// Round-robin scheduler sharing one integer divider among NCH requesters.
// Optional divider watchdog enabled by defining HWAG_DIV_SCHED_TIMEOUT_EN.
module hwag_div_sched
    import hwag_div_sched_pkg::*;
#(
    parameter int unsigned NCH         = DefNch,
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic [NCH-1:0]       req_i,
    input  logic [NCH*WIDTH-1:0] dividend_i,
    input  logic [NCH*WIDTH-1:0] divider_i,
    output logic [NCH-1:0]       pending_o,
    output logic [NCH-1:0]       done_o,
    output logic [NCH*WIDTH-1:0] quot_o,
    output logic [NCH*WIDTH-1:0] rem_o,
    output logic [NCH-1:0]       dz_o,
    output logic [NCH-1:0]       tmo_o,
    output logic                 div_start_o,
    output logic [WIDTH-1:0]     div_dividend_o,
    output logic [WIDTH-1:0]     div_divider_o,
    input  logic [WIDTH-1:0]     div_result_i,
    input  logic [WIDTH-1:0]     div_remainder_i,
    input  logic                 div_rdy_i
);

    localparam int unsigned IW = $clog2(NCH);
    localparam logic [WIDTH-1:0] AllOnes = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0]     op_dvd_q [NCH];
    logic [WIDTH-1:0]     op_dvs_q [NCH];
    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        last_q, gnt_q, pick_idx;
    logic                 pick_vld;
    logic [NCH-1:0]       pending_q, pending_d, done_q, dz_q;
    logic                 rereq_q, rereq_d, guard_q, zero_q;
    logic [WIDTH-1:0]     dvd_q, dvs_q, res_quot, res_rem;
    logic [NCH*WIDTH-1:0] quot_q, rem_q;
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
    logic [31:0]          wd_q;
    logic [NCH-1:0]       tmo_q;
    logic                 abort_q, store_tmo;
`endif

    // Only queued channels are offered; nothing is in service while in IDLE.
    hwag_rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req_i   (pending_q),
        .last_i  (last_q),
        .gnt_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req_i;
        rereq_d   = rereq_q | req_i[gnt_q];
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
        store_tmo = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // A req on the picked channel in its pick cycle must still be serviced.
                rereq_d = pick_vld && req_i[pick_idx];
                if (pick_vld) state_d = (op_dvs_q[pick_idx] == '0) ? StStore : StIssue;
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (!guard_q && div_rdy_i) begin
                    state_d = StStore;
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
                end else if (wd_q == 32'(TIMEOUT_CYC - 1)) begin
                    state_d   = StStore;
                    store_tmo = 1'b1;
`endif
                end
            end
            StStore: begin
                state_d          = StIdle;
                pending_d[gnt_q] = rereq_q | req_i[gnt_q];
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res_quot = div_result_i;
        res_rem  = div_remainder_i;
        if (zero_q) begin
            res_quot = AllOnes;
            res_rem  = dvd_q;
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
        end else if (abort_q) begin
            res_quot = AllOnes;
            res_rem  = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q   <= StIdle;
            last_q    <= IW'(NCH - 1);
            gnt_q     <= '0;
            pending_q <= '0;
            rereq_q   <= 1'b0;
            guard_q   <= 1'b0;
            zero_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            done_q    <= '0;
            dz_q      <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                op_dvd_q[i] <= '0;
                op_dvs_q[i] <= '0;
            end
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
            wd_q    <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rereq_q   <= rereq_d;
            guard_q   <= (state_q == StIssue);
            done_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (req_i[i]) begin
                    op_dvd_q[i] <= dividend_i[i*WIDTH +: WIDTH];
                    op_dvs_q[i] <= divider_i[i*WIDTH +: WIDTH];
                end
            end
            if (state_q == StIdle && pick_vld) begin
                gnt_q  <= pick_idx;
                last_q <= pick_idx;
                dvd_q  <= op_dvd_q[pick_idx];
                dvs_q  <= op_dvs_q[pick_idx];
                zero_q <= (op_dvs_q[pick_idx] == '0);
            end
            if (state_q == StStore) begin
                done_q[gnt_q]                     <= 1'b1;
                dz_q[gnt_q]                       <= zero_q;
                quot_q[32'(gnt_q)*WIDTH +: WIDTH] <= res_quot;
                rem_q[32'(gnt_q)*WIDTH +: WIDTH]  <= res_rem;
            end
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
            wd_q <= (state_q == StWait) ? wd_q + 32'd1 : '0;
            if (state_q == StIdle) abort_q <= 1'b0;
            else if (state_q == StWait && store_tmo) abort_q <= 1'b1;
            if (state_q == StStore) tmo_q[gnt_q] <= abort_q;
`endif
        end
    end

    assign pending_o      = pending_q;
    assign done_o         = done_q;
    assign dz_o           = dz_q;
    assign quot_o         = quot_q;
    assign rem_o          = rem_q;
    assign div_start_o    = (state_q == StIssue);
    assign div_dividend_o = dvd_q;
    assign div_divider_o  = dvs_q;
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
    assign tmo_o = tmo_q;
`else
    assign tmo_o = '0;
`endif

endmodule

// File: tb/tb_hwag_div_sched.sv
// Directed bench for hwag_div_sched with a behavioural 5-cycle divider model.
module tb_hwag_div_sched;

    localparam int NCH = 4;
    localparam int W   = 24;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [NCH-1:0] req = '0;
    logic [NCH*W-1:0] dividend = '0, divider = '0;
    logic [NCH-1:0] pending, done, dz, tmo;
    logic [NCH*W-1:0] quot, rem;
    logic           div_start;
    logic [W-1:0]   div_dividend, div_divider;
    logic [W-1:0]   div_result = '0, div_remainder = '0;
    logic           rdy_int = 1'b0, hold_low = 1'b0, div_rdy;
    int             cnt = 0;

    int total = 0, bad = 0;

    int got_n, first_start, first_rdy;
    int got_ch [8], got_cyc [8];
    logic [W-1:0] got_q [8], got_r [8];
    logic got_dz [8], got_tmo [8], got_pend [8];
    logic [NCH-1:0] pend1;

    hwag_div_sched dut (
        .clk_i           (clk),
        .nrst_i          (nrst),
        .req_i           (req),
        .dividend_i      (dividend),
        .divider_i       (divider),
        .pending_o       (pending),
        .done_o          (done),
        .quot_o          (quot),
        .rem_o           (rem),
        .dz_o            (dz),
        .tmo_o           (tmo),
        .div_start_o     (div_start),
        .div_dividend_o  (div_dividend),
        .div_divider_o   (div_divider),
        .div_result_i    (div_result),
        .div_remainder_i (div_remainder),
        .div_rdy_i       (div_rdy)
    );

    always #5 clk = ~clk;

    // Divider model: result level-valid 5 edges after start, held until the next start.
    assign div_rdy = rdy_int & ~hold_low;
    always @(posedge clk) begin
        if (div_start) begin
            cnt     <= 5;
            rdy_int <= 1'b0;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                rdy_int       <= 1'b1;
                div_result    <= div_dividend / div_divider;
                div_remainder <= div_dividend % div_divider;
            end
        end
    end

    task automatic set_req(input int ch, input logic [W-1:0] a, input logic [W-1:0] b);
        req[ch]              = 1'b1;
        dividend[ch*W +: W]  = a;
        divider[ch*W +: W]   = b;
    endtask

    // Runs from the request cycle (cycle 0), recording up to n done pulses; optional injected req.
    task automatic capture(input int n, input int maxcyc, input int inj_k, input int inj_ch,
                           input logic [W-1:0] inj_a, input logic [W-1:0] inj_b);
        got_n = 0; first_start = -1; first_rdy = -1; pend1 = '0;
        for (int k = 1; k <= maxcyc && got_n < n; k++) begin
            @(negedge clk);
            if (k == 1) pend1 = pending;
            if (div_start && first_start < 0) first_start = k;
            if (div_rdy && first_rdy < 0) first_rdy = k;
            for (int ch = 0; ch < NCH; ch++) begin
                if (done[ch] && got_n < 8) begin
                    got_ch[got_n]   = ch;
                    got_cyc[got_n]  = k;
                    got_q[got_n]    = quot[ch*W +: W];
                    got_r[got_n]    = rem[ch*W +: W];
                    got_dz[got_n]   = dz[ch];
                    got_tmo[got_n]  = tmo[ch];
                    got_pend[got_n] = pending[ch];
                    got_n++;
                end
            end
            req = '0;
            if (k == inj_k) set_req(inj_ch, inj_a, inj_b);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (pending !== '0) begin bad++; $display("FAIL reset_pending got %h want 0", pending); end
        total++; if (done !== '0) begin bad++; $display("FAIL reset_done got %h want 0", done); end
        total++; if ({dz, tmo} !== '0) begin bad++; $display("FAIL reset_flags got %h want 0", {dz, tmo}); end
        total++; if (div_start !== 1'b0) begin bad++; $display("FAIL reset_start got %b want 0", div_start); end
        total++; if ({quot, rem} !== '0) begin bad++; $display("FAIL reset_results got %h want 0", {quot, rem}); end
        total++; if ({div_dividend, div_divider} !== '0) begin bad++; $display("FAIL reset_operands got %h want 0", {div_dividend, div_divider}); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_req(0, 24'h2FAF08, 24'd1000);
        capture(1, 40, 0, 0, '0, '0);
        total++; if (pend1 !== 4'b0001) begin bad++; $display("FAIL single_pending got %b want 0001", pend1); end
        total++; if (first_start != 2) begin bad++; $display("FAIL single_start_cycle got %0d want 2", first_start); end
        total++; if (got_n != 1 || got_ch[0] != 0) begin bad++; $display("FAIL single_done got n=%0d ch=%0d want n=1 ch=0", got_n, got_ch[0]); end
        total++; if (got_cyc[0] != 10 || got_cyc[0] - first_rdy != 2) begin bad++; $display("FAIL single_latency got done=%0d rdy=%0d want 10/8", got_cyc[0], first_rdy); end
        total++; if (got_q[0] !== 24'd3125 || got_r[0] !== 24'd0) begin bad++; $display("FAIL single_result got %0d r %0d want 3125 r 0", got_q[0], got_r[0]); end
        total++; if ({quot[NCH*W-1:W], rem[NCH*W-1:W]} !== '0) begin bad++; $display("FAIL single_others got %h want 0", {quot[NCH*W-1:W], rem[NCH*W-1:W]}); end
        @(negedge clk);
        total++; if ({done, pending} !== '0) begin bad++; $display("FAIL single_pulse got %h want 0", {done, pending}); end
    endtask

    task automatic test_contention();
        nrst = 1'b0; @(negedge clk); nrst = 1'b1;
        set_req(0, 24'd60, 24'd7);
        set_req(2, 24'd50, 24'd5);
        capture(2, 60, 0, 0, '0, '0);
        total++; if (got_n != 2 || got_ch[0] != 0 || got_ch[1] != 2) begin bad++; $display("FAIL cont_order got n=%0d %0d,%0d want 0,2", got_n, got_ch[0], got_ch[1]); end
        total++; if (got_cyc[1] - got_cyc[0] != 9) begin bad++; $display("FAIL cont_back_to_back got gap %0d want 9", got_cyc[1] - got_cyc[0]); end
        total++; if (got_q[0] !== 24'd8 || got_r[0] !== 24'd4) begin bad++; $display("FAIL cont_ch0 got %0d r %0d want 8 r 4", got_q[0], got_r[0]); end
        total++; if (got_q[1] !== 24'd10 || got_r[1] !== 24'd0) begin bad++; $display("FAIL cont_ch2 got %0d r %0d want 10 r 0", got_q[1], got_r[1]); end
        // Lone ch0 service leaves last_grant=0, so the next search starts at ch1.
        set_req(0, 24'd3, 24'd1);
        capture(1, 40, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_q[0] !== 24'd3) begin bad++; $display("FAIL cont_lone got n=%0d q=%0d want 1/3", got_n, got_q[0]); end
        set_req(0, 24'd9, 24'd2);
        set_req(1, 24'd20, 24'd3);
        capture(2, 60, 0, 0, '0, '0);
        total++; if (got_n != 2 || got_ch[0] != 1 || got_ch[1] != 0) begin bad++; $display("FAIL cont_rotate got n=%0d %0d,%0d want 1,0", got_n, got_ch[0], got_ch[1]); end
        total++; if ({got_q[0], got_r[0], got_q[1], got_r[1]} !== {24'd6, 24'd2, 24'd4, 24'd1}) begin bad++; $display("FAIL cont_rotate_vals got %0d r%0d %0d r%0d want 6 r2 4 r1", got_q[0], got_r[0], got_q[1], got_r[1]); end
    endtask

    task automatic test_div_zero();
        set_req(1, 24'd40, 24'd0);
        capture(1, 20, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_ch[0] != 1 || got_cyc[0] != 3) begin bad++; $display("FAIL dz_timing got n=%0d ch=%0d cyc=%0d want 1/1/3", got_n, got_ch[0], got_cyc[0]); end
        total++; if (got_q[0] !== 24'hFFFFFF || got_r[0] !== 24'd40) begin bad++; $display("FAIL dz_result got %h r %0d want ffffff r 40", got_q[0], got_r[0]); end
        total++; if (got_dz[0] !== 1'b1) begin bad++; $display("FAIL dz_flag got %b want 1", got_dz[0]); end
        total++; if (first_start != -1) begin bad++; $display("FAIL dz_no_start got %0d want -1", first_start); end
        set_req(1, 24'd20, 24'd4);
        capture(1, 40, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_dz[0] !== 1'b0 || got_q[0] !== 24'd5) begin bad++; $display("FAIL dz_clear got n=%0d dz=%b q=%0d want 1/0/5", got_n, got_dz[0], got_q[0]); end
    endtask

    task automatic test_rereq();
        set_req(3, 24'd90, 24'd9);
        capture(2, 60, 4, 3, 24'd100, 24'd7);
        total++; if (got_n != 2 || got_ch[0] != 3 || got_ch[1] != 3) begin bad++; $display("FAIL rereq_count got n=%0d %0d,%0d want 2 on ch3", got_n, got_ch[0], got_ch[1]); end
        total++; if (got_q[0] !== 24'd10 || got_r[0] !== 24'd0) begin bad++; $display("FAIL rereq_first got %0d r %0d want 10 r 0", got_q[0], got_r[0]); end
        total++; if (got_pend[0] !== 1'b1) begin bad++; $display("FAIL rereq_pending got %b want 1", got_pend[0]); end
        total++; if (got_q[1] !== 24'd14 || got_r[1] !== 24'd2) begin bad++; $display("FAIL rereq_second got %0d r %0d want 14 r 2", got_q[1], got_r[1]); end
    endtask

    task automatic test_timeout();
        hold_low = 1'b1;
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
        set_req(2, 24'd7, 24'd1);
        set_req(3, 24'd8, 24'd2);
        capture(1, 100, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_ch[0] != 2 || got_cyc[0] != 68) begin bad++; $display("FAIL tmo_timing got n=%0d ch=%0d cyc=%0d want 1/2/68", got_n, got_ch[0], got_cyc[0]); end
        total++; if (got_tmo[0] !== 1'b1 || got_q[0] !== 24'hFFFFFF || got_r[0] !== 24'd0) begin bad++; $display("FAIL tmo_result got tmo=%b %h r %0d want 1 ffffff r 0", got_tmo[0], got_q[0], got_r[0]); end
        hold_low = 1'b0;
        capture(1, 40, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_ch[0] != 3 || got_tmo[0] !== 1'b0 || got_q[0] !== 24'd4) begin bad++; $display("FAIL tmo_next got n=%0d ch=%0d tmo=%b q=%0d want 1/3/0/4", got_n, got_ch[0], got_tmo[0], got_q[0]); end
`else
        set_req(2, 24'd7, 24'd1);
        capture(1, 80, 0, 0, '0, '0);
        total++; if (got_n != 0 || tmo !== '0) begin bad++; $display("FAIL hold_no_abort got n=%0d tmo=%b want 0/0", got_n, tmo); end
        hold_low = 1'b0;
        capture(1, 10, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_ch[0] != 2 || got_q[0] !== 24'd7 || got_tmo[0] !== 1'b0) begin bad++; $display("FAIL hold_release got n=%0d ch=%0d q=%0d tmo=%b want 1/2/7/0", got_n, got_ch[0], got_q[0], got_tmo[0]); end
`endif
        hold_low = 1'b0;
    endtask

    task automatic test_reset_wait();
        int ndone;
        set_req(0, 24'd30, 24'd3);
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        total++; if ({pending, done, div_start} !== '0) begin bad++; $display("FAIL rstw_ctrl got %h want 0", {pending, done, div_start}); end
        total++; if ({quot, rem, div_dividend, div_divider} !== '0) begin bad++; $display("FAIL rstw_data got nonzero want 0"); end
        nrst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done != '0) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL rstw_no_done got %0d want 0", ndone); end
        set_req(1, 24'd12, 24'd4);
        capture(1, 40, 0, 0, '0, '0);
        total++; if (got_n != 1 || got_ch[0] != 1 || got_q[0] !== 24'd3 || got_r[0] !== 24'd0) begin bad++; $display("FAIL rstw_after got n=%0d ch=%0d %0d r %0d want 1/1/3 r 0", got_n, got_ch[0], got_q[0], got_r[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_div_zero();
        test_rereq();
        test_timeout();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
